// File: rtl/pipelined_control_unit_if.sv
// Bundles the decode-stage inputs and the ID/EX control outputs of
// pipelined_control_unit.
//   slave  : the control unit (samples instruction/hazard inputs, drives stall/flush/control word)
//   master : the surrounding pipeline or a testbench (drives instruction/hazard inputs)
// Signals: valid_in, opcode, funct, rs1, rs2, ex_rd, ex_mem_read, branch_taken (to unit);
//          stall, flush, 18-bit control word fields, ctrl_valid, illegal_op (from unit).
interface pipelined_control_unit_if #(
    parameter int unsigned OP_W = 5,
    parameter int unsigned FN_W = 3,
    parameter int unsigned RA_W = 4
) ();
    logic            valid_in;
    logic [OP_W-1:0] opcode;
    logic [FN_W-1:0] funct;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] ex_rd;
    logic            ex_mem_read;
    logic            branch_taken;

    logic            stall;
    logic            flush;
    logic [1:0]      jmp_sel;
    logic            write_register;
    logic            mem_write;
    logic [1:0]      reg_write;
    logic [1:0]      vcsub;
    logic [2:0]      alu_op;
    logic [1:0]      sel_op_b;
    logic            sel_rs2;
    logic [1:0]      branch_sel;
    logic            sel_op_a;
    logic            sel_write_data;
    logic            ctrl_valid;
    logic            illegal_op;

    modport slave (
        input  valid_in, opcode, funct, rs1, rs2, ex_rd, ex_mem_read, branch_taken,
        output stall, flush, jmp_sel, write_register, mem_write, reg_write, vcsub,
               alu_op, sel_op_b, sel_rs2, branch_sel, sel_op_a, sel_write_data,
               ctrl_valid, illegal_op
    );

    modport master (
        output valid_in, opcode, funct, rs1, rs2, ex_rd, ex_mem_read, branch_taken,
        input  stall, flush, jmp_sel, write_register, mem_write, reg_write, vcsub,
               alu_op, sel_op_b, sel_rs2, branch_sel, sel_op_a, sel_write_data,
               ctrl_valid, illegal_op
    );
endinterface

// File: rtl/pipelined_control_unit.sv
// Registered instruction decoder with hazard control for the interpolation ASIP.
// Decodes {opcode, funct} into an 18-bit control word latched in the ID/EX
// register, stalls on load-use hazards and multi-cycle multiplies, flushes on
// taken branches/jumps and pulses illegal_op for unknown encodings.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : pipelined_control_unit_if.slave (instruction/hazard inputs,
//          combinational stall/flush, registered control word, ctrl_valid, illegal_op)
module pipelined_control_unit #(
    parameter int unsigned OP_W    = 5,
    parameter int unsigned FN_W    = 3,
    parameter int unsigned RA_W    = 4,
    parameter int unsigned MUL_LAT = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    pipelined_control_unit_if.slave   bus
);
    localparam int unsigned KEY_W  = OP_W + FN_W;
    localparam int unsigned MCNT_W = $clog2(MUL_LAT + 1);

    typedef struct packed {
        logic [1:0] jmp_sel;
        logic       write_register;
        logic       mem_write;
        logic [1:0] reg_write;
        logic [1:0] vcsub;
        logic [2:0] alu_op;
        logic [1:0] sel_op_b;
        logic       sel_rs2;
        logic [1:0] branch_sel;
        logic       sel_op_a;
        logic       sel_write_data;
    } ctrl_t;

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [MCNT_W-1:0] mcnt_q, mcnt_d;
    ctrl_t             ctrl_q, ctrl_d, dec;
    logic              ctrl_valid_q, ctrl_valid_d;
    logic              illegal_q, illegal_d;
    logic              legal, is_mul, hazard;
    logic              stall_c, flush_c;
    logic [KEY_W-1:0]  key;
    logic [RA_W-1:0]   rs1, rs2, ex_rd;

    assign key   = {bus.opcode, bus.funct};
    assign rs1   = bus.rs1;
    assign rs2   = bus.rs2;
    assign ex_rd = bus.ex_rd;

    // Load-use: the load in EX writes a register this instruction reads (r0 never hazards)
    assign hazard = bus.valid_in && bus.ex_mem_read && (ex_rd != '0)
                    && ((ex_rd == rs1) || (ex_rd == rs2));

    // Pure decode table; unused fields stay 0
    always_comb begin
        dec    = '0;
        legal  = 1'b1;
        is_mul = 1'b0;
        case (key)
            KEY_W'(8'b00000_000): begin dec.write_register = 1'b1; dec.reg_write = 2'b01; dec.alu_op = 3'b000; end
            KEY_W'(8'b01000_000): begin dec.write_register = 1'b1; dec.reg_write = 2'b01; dec.alu_op = 3'b000; dec.sel_op_b = 2'b01; end
            KEY_W'(8'b00000_001): begin dec.write_register = 1'b1; dec.reg_write = 2'b01; dec.alu_op = 3'b001; end
            KEY_W'(8'b01001_001): begin dec.write_register = 1'b1; dec.reg_write = 2'b01; dec.alu_op = 3'b001; dec.sel_op_b = 2'b01; end
            KEY_W'(8'b00000_010): begin dec.write_register = 1'b1; dec.reg_write = 2'b01; dec.alu_op = 3'b010; is_mul = 1'b1; end
            KEY_W'(8'b00000_100): begin dec.write_register = 1'b1; dec.reg_write = 2'b01; dec.alu_op = 3'b100; end
            KEY_W'(8'b00000_101): begin dec.write_register = 1'b1; dec.reg_write = 2'b01; dec.alu_op = 3'b101; end
            KEY_W'(8'b00000_110): begin dec.write_register = 1'b1; dec.reg_write = 2'b01; dec.alu_op = 3'b110; end
            KEY_W'(8'b00010_000): begin dec.write_register = 1'b1; dec.sel_op_b = 2'b10; dec.sel_rs2 = 1'b1; end
            KEY_W'(8'b00011_000): begin dec.write_register = 1'b1; dec.sel_op_b = 2'b10; dec.sel_rs2 = 1'b1; dec.sel_write_data = 1'b1; end
            KEY_W'(8'b00100_000): begin dec.mem_write = 1'b1; dec.sel_rs2 = 1'b1; end
            KEY_W'(8'b00101_000): begin dec.mem_write = 1'b1; dec.sel_rs2 = 1'b1; dec.sel_op_a = 1'b1; dec.sel_write_data = 1'b1; end
            KEY_W'(8'b10000_000): begin dec.jmp_sel = 2'b01; end
            KEY_W'(8'b00110_000): begin dec.jmp_sel = 2'b10; end
            KEY_W'(8'b10001_000): begin dec.jmp_sel = 2'b01; dec.write_register = 1'b1; dec.reg_write = 2'b10; end
            KEY_W'(8'b01010_000): begin dec.jmp_sel = 2'b01; dec.branch_sel = 2'b01; dec.alu_op = 3'b001; end
            KEY_W'(8'b01011_000): begin dec.jmp_sel = 2'b10; dec.branch_sel = 2'b01; dec.alu_op = 3'b001; end
            default:              legal = 1'b0;
        endcase
    end

    // Next state, next control word and stall/flush, in priority order
    always_comb begin
        state_d      = state_q;
        mcnt_d       = mcnt_q;
        ctrl_d       = '0;
        ctrl_valid_d = 1'b0;
        illegal_d    = 1'b0;
        stall_c      = 1'b0;
        flush_c      = 1'b0;
        if (bus.branch_taken) begin
            flush_c = 1'b1;
            state_d = IDLE;
            mcnt_d  = '0;
        end else if (state_q == MUL_BUSY) begin
            stall_c = 1'b1;
            mcnt_d  = mcnt_q - MCNT_W'(1);
            if (mcnt_q == MCNT_W'(1)) begin
                state_d = IDLE;
            end
        end else if (hazard) begin
            stall_c = 1'b1;
        end else if (bus.valid_in) begin
            if (legal) begin
                ctrl_d       = dec;
                ctrl_valid_d = 1'b1;
                // Multi-cycle multiply: hold the front end for MUL_LAT-1 cycles
                if (is_mul) begin
                    mcnt_d = MCNT_W'(MUL_LAT - 1);
                    if (MUL_LAT > 1) begin
                        state_d = MUL_BUSY;
                    end
                end
            end else begin
                illegal_d = 1'b1;
            end
        end
    end

    // State, counter and ID/EX register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            mcnt_q       <= '0;
            ctrl_q       <= '0;
            ctrl_valid_q <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mcnt_q       <= mcnt_d;
            ctrl_q       <= ctrl_d;
            ctrl_valid_q <= ctrl_valid_d;
            illegal_q    <= illegal_d;
        end
    end

    // Reset overrides the combinational hazard outputs
    assign bus.stall          = stall_c & ~rst;
    assign bus.flush          = flush_c & ~rst;
    assign bus.jmp_sel        = ctrl_q.jmp_sel;
    assign bus.write_register = ctrl_q.write_register;
    assign bus.mem_write      = ctrl_q.mem_write;
    assign bus.reg_write      = ctrl_q.reg_write;
    assign bus.vcsub          = ctrl_q.vcsub;
    assign bus.alu_op         = ctrl_q.alu_op;
    assign bus.sel_op_b       = ctrl_q.sel_op_b;
    assign bus.sel_rs2        = ctrl_q.sel_rs2;
    assign bus.branch_sel     = ctrl_q.branch_sel;
    assign bus.sel_op_a       = ctrl_q.sel_op_a;
    assign bus.sel_write_data = ctrl_q.sel_write_data;
    assign bus.ctrl_valid     = ctrl_valid_q;
    assign bus.illegal_op     = illegal_q;
endmodule

// File: tb/tb_pipelined_control_unit.sv
// Self-checking bench for pipelined_control_unit (MUL_LAT = 3).
// Expected registered outputs are queued when stimulus is driven and compared
// one edge later; combinational stall/flush are checked right after driving.
module tb_pipelined_control_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipelined_control_unit_if #(.OP_W(5), .FN_W(3), .RA_W(4)) bus ();

    pipelined_control_unit #(.OP_W(5), .FN_W(3), .RA_W(4), .MUL_LAT(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    logic [19:0] exp_q[$];
    logic [19:0] got, want;

    localparam logic [19:0] BUBBLE  = 20'h0;
    localparam logic [19:0] ILLEGAL = {2'b01, 18'h0};

    // {ctrl_valid, illegal_op, 18-bit control word}
    function automatic logic [19:0] obs();
        return {bus.ctrl_valid, bus.illegal_op, bus.jmp_sel, bus.write_register, bus.mem_write,
                bus.reg_write, bus.vcsub, bus.alu_op, bus.sel_op_b, bus.sel_rs2,
                bus.branch_sel, bus.sel_op_a, bus.sel_write_data};
    endfunction

    // Valid control word built field by field (vcsub always 0)
    function automatic logic [19:0] vw(input logic [1:0] j, input logic w, input logic m,
                                       input logic [1:0] rw, input logic [2:0] alu,
                                       input logic [1:0] sob, input logic s2,
                                       input logic [1:0] bs, input logic sa, input logic sd);
        return {2'b10, j, w, m, rw, 2'b00, alu, sob, s2, bs, sa, sd};
    endfunction

    task automatic drive(input logic v, input logic [4:0] op, input logic [2:0] fn);
        bus.valid_in     = v;
        bus.opcode       = op;
        bus.funct        = fn;
        bus.rs1          = 4'd1;
        bus.rs2          = 4'd2;
        bus.ex_rd        = 4'd0;
        bus.ex_mem_read  = 1'b0;
        bus.branch_taken = 1'b0;
    endtask

    task automatic test_reset();
        drive(1'b1, 5'b00000, 3'b000);
        bus.branch_taken = 1'b1;
        #3 rst = 1'b1;
        #1;
        vectors++;
        if ({bus.stall, bus.flush, obs()} !== 22'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want %h", {bus.stall, bus.flush, obs()}, 22'h0);
        end
        @(negedge clk);
        @(negedge clk);
        bus.branch_taken = 1'b0;
        rst = 1'b0;
        exp_q.push_back(vw(2'b00, 1, 0, 2'b01, 3'b000, 2'b00, 0, 2'b00, 0, 0));
        @(negedge clk);
        got = obs(); want = exp_q.pop_front(); vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL reset_then_add: got %h want %h", got, want);
        end
    endtask

    task automatic test_decode_sweep();
        logic        v_t   [24];
        logic [7:0]  key_t [24];
        logic [19:0] exp_t [24];
        logic [7:0]  k;
        v_t  = '{default: 1'b1};
        key_t[0]  = 8'b00000_000; exp_t[0]  = vw(2'b00, 1, 0, 2'b01, 3'b000, 2'b00, 0, 2'b00, 0, 0);
        key_t[1]  = 8'b01000_000; exp_t[1]  = vw(2'b00, 1, 0, 2'b01, 3'b000, 2'b01, 0, 2'b00, 0, 0);
        key_t[2]  = 8'b00000_001; exp_t[2]  = vw(2'b00, 1, 0, 2'b01, 3'b001, 2'b00, 0, 2'b00, 0, 0);
        key_t[3]  = 8'b01001_001; exp_t[3]  = vw(2'b00, 1, 0, 2'b01, 3'b001, 2'b01, 0, 2'b00, 0, 0);
        key_t[4]  = 8'b00000_100; exp_t[4]  = vw(2'b00, 1, 0, 2'b01, 3'b100, 2'b00, 0, 2'b00, 0, 0);
        key_t[5]  = 8'b00000_101; exp_t[5]  = vw(2'b00, 1, 0, 2'b01, 3'b101, 2'b00, 0, 2'b00, 0, 0);
        key_t[6]  = 8'b00000_110; exp_t[6]  = vw(2'b00, 1, 0, 2'b01, 3'b110, 2'b00, 0, 2'b00, 0, 0);
        key_t[7]  = 8'b00010_000; exp_t[7]  = vw(2'b00, 1, 0, 2'b00, 3'b000, 2'b10, 1, 2'b00, 0, 0);
        key_t[8]  = 8'b00011_000; exp_t[8]  = vw(2'b00, 1, 0, 2'b00, 3'b000, 2'b10, 1, 2'b00, 0, 1);
        key_t[9]  = 8'b00100_000; exp_t[9]  = vw(2'b00, 0, 1, 2'b00, 3'b000, 2'b00, 1, 2'b00, 0, 0);
        key_t[10] = 8'b00101_000; exp_t[10] = vw(2'b00, 0, 1, 2'b00, 3'b000, 2'b00, 1, 2'b00, 1, 1);
        key_t[11] = 8'b10000_000; exp_t[11] = vw(2'b01, 0, 0, 2'b00, 3'b000, 2'b00, 0, 2'b00, 0, 0);
        key_t[12] = 8'b00110_000; exp_t[12] = vw(2'b10, 0, 0, 2'b00, 3'b000, 2'b00, 0, 2'b00, 0, 0);
        key_t[13] = 8'b10001_000; exp_t[13] = vw(2'b01, 1, 0, 2'b10, 3'b000, 2'b00, 0, 2'b00, 0, 0);
        key_t[14] = 8'b01010_000; exp_t[14] = vw(2'b01, 0, 0, 2'b00, 3'b001, 2'b00, 0, 2'b01, 0, 0);
        key_t[15] = 8'b01011_000; exp_t[15] = vw(2'b10, 0, 0, 2'b00, 3'b001, 2'b00, 0, 2'b01, 0, 0);
        key_t[16] = 8'b00000_010; exp_t[16] = vw(2'b00, 1, 0, 2'b01, 3'b010, 2'b00, 0, 2'b00, 0, 0);
        // MUL busy window: idle slots give bubbles
        key_t[17] = 8'b00000_000; exp_t[17] = BUBBLE; v_t[17] = 1'b0;
        key_t[18] = 8'b00000_000; exp_t[18] = BUBBLE; v_t[18] = 1'b0;
        key_t[19] = 8'b11111_111; exp_t[19] = ILLEGAL;
        key_t[20] = 8'b00000_011; exp_t[20] = ILLEGAL;
        key_t[21] = 8'b00000_000; exp_t[21] = vw(2'b00, 1, 0, 2'b01, 3'b000, 2'b00, 0, 2'b00, 0, 0);
        // valid_in = 0 with an illegal key: bubble, not illegal
        key_t[22] = 8'b11111_111; exp_t[22] = BUBBLE; v_t[22] = 1'b0;
        key_t[23] = 8'b10000_000; exp_t[23] = vw(2'b01, 0, 0, 2'b00, 3'b000, 2'b00, 0, 2'b00, 0, 0);
        for (int i = 0; i < 24; i++) begin
            k = key_t[i];
            drive(v_t[i], k[7:3], k[2:0]);
            exp_q.push_back(exp_t[i]);
            @(negedge clk);
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL sweep_queue_empty: got 0 entries want 1");
            end else begin
                got = obs(); want = exp_q.pop_front(); vectors++;
                if (got !== want) begin
                    miscompares++;
                    $display("FAIL sweep_%0d key %b: got %h want %h", i, k, got, want);
                end
            end
        end
    endtask

    task automatic test_load_use();
        logic [19:0] add_w;
        add_w = vw(2'b00, 1, 0, 2'b01, 3'b000, 2'b00, 0, 2'b00, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'b00000, 3'b000);
            bus.ex_mem_read = (i != 2);
            bus.ex_rd       = (i == 3) ? 4'd0 : 4'd5;
            bus.rs2         = (i == 0) ? 4'd5 : 4'd2;
            bus.rs1         = (i == 1) ? 4'd5 : ((i == 3) ? 4'd0 : 4'd1);
            exp_q.push_back((i < 2) ? BUBBLE : add_w);
            #1;
            vectors++;
            if ({bus.stall, bus.flush} !== {(i < 2), 1'b0}) begin
                miscompares++;
                $display("FAIL load_use_stall_%0d: got %b want %b", i, {bus.stall, bus.flush}, {(i < 2), 1'b0});
            end
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL load_use_word_%0d: got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_mul_stall();
        int stalls = 0;
        drive(1'b1, 5'b00000, 3'b010);
        exp_q.push_back(vw(2'b00, 1, 0, 2'b01, 3'b010, 2'b00, 0, 2'b00, 0, 0));
        @(negedge clk);
        got = obs(); want = exp_q.pop_front(); vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL mul_word: got %h want %h", got, want);
        end
        // ADD waits through the busy window then latches on the 3rd edge
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'b00000, 3'b000);
            exp_q.push_back((i < 2) ? BUBBLE : vw(2'b00, 1, 0, 2'b01, 3'b000, 2'b00, 0, 2'b00, 0, 0));
            #1;
            if (bus.stall === 1'b1) stalls++;
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL mul_follow_%0d: got %h want %h", i, got, want);
            end
        end
        vectors++;
        if (stalls != 2) begin
            miscompares++;
            $display("FAIL mul_stall_cycles: got %0d want 2", stalls);
        end
    endtask

    task automatic test_branch_in_mul();
        drive(1'b1, 5'b00000, 3'b010);
        exp_q.push_back(vw(2'b00, 1, 0, 2'b01, 3'b010, 2'b00, 0, 2'b00, 0, 0));
        @(negedge clk);
        got = obs(); want = exp_q.pop_front(); vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL branch_mul_word: got %h want %h", got, want);
        end
        // phase 0: branch in first busy cycle; 1: MUL with branch; 2: ADD after, no stall
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'b00000, (i == 1) ? 3'b010 : 3'b000);
            bus.branch_taken = (i < 2);
            exp_q.push_back((i < 2) ? BUBBLE : vw(2'b00, 1, 0, 2'b01, 3'b000, 2'b00, 0, 2'b00, 0, 0));
            #1;
            vectors++;
            if ({bus.stall, bus.flush} !== {1'b0, (i < 2)}) begin
                miscompares++;
                $display("FAIL branch_flush_%0d: got %b want %b", i, {bus.stall, bus.flush}, {1'b0, (i < 2)});
            end
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL branch_word_%0d: got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_simultaneous();
        drive(1'b1, 5'b00000, 3'b000);
        bus.ex_mem_read  = 1'b1;
        bus.ex_rd        = 4'd5;
        bus.rs1          = 4'd5;
        bus.branch_taken = 1'b1;
        exp_q.push_back(BUBBLE);
        #1;
        vectors++;
        if ({bus.stall, bus.flush} !== 2'b01) begin
            miscompares++;
            $display("FAIL simul_hazard: got %b want 01", {bus.stall, bus.flush});
        end
        @(negedge clk);
        got = obs(); want = exp_q.pop_front(); vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL simul_word: got %h want %h", got, want);
        end
    endtask

    task automatic test_reset_mid_busy();
        drive(1'b1, 5'b00000, 3'b010);
        @(negedge clk);
        drive(1'b1, 5'b00000, 3'b000);
        #1;
        vectors++;
        if (bus.stall !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_before_reset: got %b want 1", bus.stall);
        end
        #1 rst = 1'b1;
        #1;
        vectors++;
        if ({bus.stall, obs()} !== 21'h0) begin
            miscompares++;
            $display("FAIL reset_mid_busy: got %h want %h", {bus.stall, obs()}, 21'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(vw(2'b00, 1, 0, 2'b01, 3'b000, 2'b00, 0, 2'b00, 0, 0));
        #1;
        vectors++;
        if (bus.stall !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_after_reset: got %b want 0", bus.stall);
        end
        @(negedge clk);
        got = obs(); want = exp_q.pop_front(); vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL add_after_reset: got %h want %h", got, want);
        end
    endtask

    initial begin
        test_reset();
        test_decode_sweep();
        test_load_use();
        test_mul_stall();
        test_branch_in_mul();
        test_simultaneous();
        test_reset_mid_busy();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
